serial_frame_tx: RTL and testbench

- Transmit end of the 16-state serial frame protocol: accepts a parallel word via valid/ready and emits it MSB-first, one bit per clock.
- Drives the 4-bit frame state and the data-bit window to the receive side, which resets its shift register in state 0 and clocks it during states 2..13.
- Sits between the sample/data source and the serial link.

---
 rtl/serial_frame_pkg.sv | 14 +
 rtl/serial_frame_tx_piso_shift.sv | 37 +++
 rtl/serial_frame_tx.sv | 104 ++++++++++
 tb/tb_serial_frame_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared constants and FSM state type for the serial frame transmitter.
package serial_frame_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 16;
  localparam int LEAD      = 2;
  localparam int STATE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// Parallel-in/serial-out register: loads a word, then shifts left MSB-first, filling with 0.
module piso_shift #(
  parameter int W = 12
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         msb
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Next shift-register contents; a load wins over a shift.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end
  end

  // Shift-register storage, cleared on reset so no stale word survives an abort.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Transmit side of the 16-state serial frame link: valid/ready word intake,
// frame state counter and MSB-first serial data over the data window.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = serial_frame_pkg::DATA_W,
  parameter int FRAME_LEN = serial_frame_pkg::FRAME_LEN,
  parameter int LEAD      = serial_frame_pkg::LEAD
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [STATE_W-1:0] state,
  output logic               sdata,
  output logic               bit_en,
  output logic               frame_sync,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [STATE_W-1:0] CNT_LAST  = STATE_W'(FRAME_LEN - 1);
  localparam logic [STATE_W-1:0] WIN_FIRST = STATE_W'(LEAD);
  localparam logic [STATE_W-1:0] WIN_LAST  = STATE_W'(LEAD + DATA_W - 1);

  if (LEAD + DATA_W > FRAME_LEN) begin : g_bad_window
    $error("serial_frame_tx: data window LEAD+DATA_W exceeds FRAME_LEN");
  end
  if (FRAME_LEN > (1 << STATE_W)) begin : g_bad_len
    $error("serial_frame_tx: FRAME_LEN does not fit the state counter");
  end

  tx_state_t          fsm_q, fsm_d;
  logic [STATE_W-1:0] cnt_q, cnt_d;
  logic               alive_q, alive_d;
  logic               at_last;
  logic               xfer;
  logic               msb;

  // alive_q keeps tx_ready low while in reset and through the release edge.
  assign at_last  = (fsm_q == FRAME) && (cnt_q == CNT_LAST);
  assign tx_ready = alive_q && ((fsm_q == IDLE) || at_last);
  assign xfer     = tx_valid && tx_ready;

  // Next-state and counter logic; the last frame state can chain straight into a new frame.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    alive_d = 1'b1;
    case (fsm_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          fsm_d = FRAME;
        end
      end
      FRAME: begin
        if (at_last) begin
          cnt_d = '0;
          fsm_d = xfer ? FRAME : IDLE;
        end else begin
          cnt_d = cnt_q + STATE_W'(1);
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // State register; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
    end
  end

  assign busy       = (fsm_q == FRAME);
  assign state      = cnt_q;
  assign frame_sync = busy && (cnt_q == '0);
  assign frame_done = at_last;
  assign bit_en     = busy && (cnt_q >= WIN_FIRST) && (cnt_q <= WIN_LAST);
  assign sdata      = bit_en && msb;

  piso_shift #(
    .W(DATA_W)
  ) u_piso (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .load      (xfer),
    .load_data (tx_data),
    .shift_en  (bit_en),
    .msb       (msb)
  );

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx against a frame-position reference model.
module tb_serial_frame_tx;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [3:0]  state;
  logic        sdata, bit_en, frame_sync, frame_done, busy;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: position within the frame (-1 = idle) and the word in flight.
  int          m_p = -1;
  logic [11:0] m_word = '0;
  bit          m_alive = 0;
  bit          m_xfer = 0;

  logic [11:0] cap = '0;
  logic [11:0] last_word = '0;

  always #5 clk_in = ~clk_in;

  serial_frame_tx dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .state      (state),
    .sdata      (sdata),
    .bit_en     (bit_en),
    .frame_sync (frame_sync),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_alive && (m_p < 0 || m_p == 15);
  endfunction

  function automatic logic [9:0] m_vec();
    bit         be;
    bit         sd;
    logic [3:0] st;
    be = (m_p >= 2) && (m_p <= 13);
    sd = be ? m_word[13 - m_p] : 1'b0;
    st = (m_p < 0) ? 4'd0 : 4'(m_p);
    return {st, sd, be, (m_p == 0), (m_p == 15), (m_p >= 0), m_ready()};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {state, sdata, bit_en, frame_sync, frame_done, busy, tx_ready};
  endfunction

  task automatic model_reset();
    m_p = -1;
    m_alive = 0;
    m_xfer = 0;
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = m_ready();
    m_xfer = 0;
    if (rdy && tx_valid) begin
      m_p = 0;
      m_word = tx_data;
      m_xfer = 1;
    end else if (m_p == 15) begin
      m_p = -1;
    end else if (m_p >= 0) begin
      m_p++;
    end
    m_alive = 1;
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1ns later.
  task automatic step();
    @(posedge clk_in);
    if (rst_n) model_edge();
    else m_xfer = 0;
    #1;
    chk("outputs", 32'(dut_vec()), 32'(m_vec()));
    if (m_xfer) cap = '0;
    if (m_p >= 2 && m_p <= 13) cap = {cap[10:0], sdata};
    if (m_p == 15) last_word = cap;
  endtask

  task automatic send(input logic [11:0] w);
    bit done;
    done = 0;
    tx_valid = 1'b1;
    tx_data = w;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = m_xfer;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    bit done;
    done = (m_p == p);
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = (m_p == p);
    end
    if (!done) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step();
    chk("rst_ready", 32'(tx_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_outputs", 32'(dut_vec()), 32'(m_vec()));
    step();
    chk("rel_ready", 32'(tx_ready), 32'd1);

    // Single frame, then valid low across state 15
    send(12'hA5C);
    chk("single_sync", 32'(frame_sync), 32'd1);
    wait_pos(15);
    chk("single_word", 32'(last_word), 32'hA5C);
    step();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_ready", 32'(tx_ready), 32'd1);

    // Idle gap
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gap_ready", 32'(tx_ready), 32'd1);
      chk("gap_quiet", 32'({state, bit_en, frame_sync, sdata}), 32'd0);
    end

    // Back-to-back frames with no gap cycle
    send(12'hFFF);
    send(12'h000);
    chk("b2b_sync", 32'(frame_sync), 32'd1);
    chk("b2b_word1", 32'(last_word), 32'hFFF);
    wait_pos(15);
    chk("b2b_word2", 32'(last_word), 32'h000);
    step();

    // Mid-frame valid is held off until state 15; data changes are ignored
    send(12'hA5C);
    wait_pos(5);
    tx_valid = 1'b1;
    tx_data = 12'h123;
    for (int i = 0; i < 40 && !m_xfer; i++) begin
      if (m_p >= 5 && m_p <= 14) chk("mid_not_ready", 32'(tx_ready), 32'd0);
      step();
      if (!m_xfer) tx_data = (m_p >= 6 && m_p <= 14) ? 12'($urandom) : 12'h123;
    end
    chk("mid_accept", 32'(m_xfer), 32'd1);
    chk("mid_last_word", 32'(last_word), 32'hA5C);
    tx_valid = 1'b0;
    tx_data = 12'($urandom);
    wait_pos(15);
    chk("mid_word", 32'(last_word), 32'h123);
    step();

    // Asynchronous reset mid-frame
    send(12'hA5C);
    wait_pos(7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_outputs", 32'(dut_vec()), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("arst_ready", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 3; i++) step();
    send(12'h5A3);
    wait_pos(15);
    chk("arst_word", 32'(last_word), 32'h5A3);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data = 12'($urandom);
      step();
      if (m_p == 15) chk("rnd_word", 32'(last_word), 32'(m_word));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
